tlp_rx_filter: RTL

//  Snoop-side TLP class filter on pcie_clk, between the PCIe RX AXIS tap and pcie2fifo.

---
 rtl/tlp_rx_filter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tlp_rx_filter.sv
// Snoop-side PCIe RX TLP class filter: classifies each TLP on its first beat,
// forwards or drops the whole TLP per a class mask, and counts outcomes.
module tlp_rx_filter #(
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst,
    input  logic                    in_tvalid,
    input  logic                    in_tready,
    input  logic [C_DATA_WIDTH-1:0] in_tdata,
    input  logic [KEEP_WIDTH-1:0]   in_tkeep,
    input  logic                    in_tlast,
    input  logic [21:0]             in_tuser,
    input  logic                    filt_en,
    input  logic [7:0]              class_mask,
    input  logic                    cnt_clr,
    output logic                    out_tvalid,
    output logic                    out_tready,
    output logic [C_DATA_WIDTH-1:0] out_tdata,
    output logic [KEEP_WIDTH-1:0]   out_tkeep,
    output logic                    out_tlast,
    output logic [21:0]             out_tuser,
    output logic [CNT_WIDTH-1:0]    pass_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt
);

    typedef enum logic [1:0] {
        ST_SOP,
        ST_PASS,
        ST_DROP
    } state_t;

    typedef enum logic [2:0] {
        CL_MRD   = 3'd0,
        CL_MWR   = 3'd1,
        CL_CPL   = 3'd2,
        CL_CPLD  = 3'd3,
        CL_CFG   = 3'd4,
        CL_MSG   = 3'd5,
        CL_IO    = 3'd6,
        CL_OTHER = 3'd7
    } tlp_class_t;

    state_t                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [C_DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0]   keep_q, keep_d;
    logic                    last_q, last_d;
    logic [21:0]             user_q, user_d;
    logic [CNT_WIDTH-1:0]    pass_q, pass_d;
    logic [CNT_WIDTH-1:0]    drop_q, drop_d;

    logic       beat;
    logic       sop_beat;
    logic       keep_tlp;
    logic       fwd;
    logic [1:0] fmt;
    logic [4:0] typ;
    tlp_class_t cls;

    always_comb begin
        fmt = in_tdata[30:29];
        typ = in_tdata[28:24];
        cls = CL_OTHER;
        if (typ[4:1] == 4'b0000) begin
            cls = fmt[1] ? CL_MWR : CL_MRD;
        end else if (typ == 5'b00010) begin
            cls = CL_IO;
        end else if (typ[4:1] == 4'b0010) begin
            cls = CL_CFG;
        end else if (typ[4:3] == 2'b10) begin
            cls = CL_MSG;
        end else if (typ[4:1] == 4'b0101) begin
            cls = fmt[1] ? CL_CPLD : CL_CPL;
        end
    end

    assign beat     = in_tvalid & in_tready;
    assign sop_beat = beat & (state_q == ST_SOP);
    assign keep_tlp = ~filt_en | class_mask[cls];
    assign fwd      = (sop_beat & keep_tlp) | (beat & (state_q == ST_PASS));

    always_comb begin
        state_d = state_q;
        if (beat) begin
            if (in_tlast) begin
                state_d = ST_SOP;
            end else if (state_q == ST_SOP) begin
                state_d = keep_tlp ? ST_PASS : ST_DROP;
            end
        end
    end

    always_comb begin
        valid_d = fwd;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        if (fwd) begin
            data_d = in_tdata;
            keep_d = in_tkeep;
            last_d = in_tlast;
            user_d = in_tuser;
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        pass_d = pass_q;
        drop_d = drop_q;
        if (cnt_clr) begin
            pass_d = '0;
            drop_d = '0;
        end else if (sop_beat) begin
            if (keep_tlp && (pass_q != '1)) begin
                pass_d = pass_q + 1'b1;
            end
            if (!keep_tlp && (drop_q != '1)) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q <= ST_SOP;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            pass_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
            pass_q  <= pass_d;
            drop_q  <= drop_d;
        end
    end

    assign out_tvalid = valid_q;
    assign out_tready = valid_q;
    assign out_tdata  = data_q;
    assign out_tkeep  = keep_q;
    assign out_tlast  = last_q;
    assign out_tuser  = user_q;
    assign pass_cnt   = pass_q;
    assign drop_cnt   = drop_q;

endmodule
